// File: rtl/dec_scan_sequencer_if.sv
// Control and decoder-drive signals of the scan sequencer.
// The controlling agent uses master; the sequencer uses slave.
interface dec_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic [3:0] req;
  logic       a;
  logic       b;
  logic       en;
  logic       busy;
  logic       sweep_done;

  modport master (
    output start, stop, req,
    input  a, b, en, busy, sweep_done
  );

  modport slave (
    input  start, stop, req,
    output a, b, en, busy, sweep_done
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Round-robin channel scanner driving the a/b/en inputs of a 2-to-4 decoder.
// Each requesting channel is held for DWELL cycles, with an idle gap between grants.
module dec_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dec_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [CW-1:0] LOAD = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          found;
  logic [1:0]    hit;
  logic [1:0]    probe;
  logic [1:0]    top_bit;

  // First requesting channel at or after ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    hit   = ptr_q;
    probe = ptr_q;
    for (int i = 0; i < 4; i++) begin
      probe = ptr_q + 2'(i);
      if (!found && bus.req[probe]) begin
        found = 1'b1;
        hit   = probe;
      end
    end
  end

  always_comb begin
    top_bit = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) top_bit = 2'(i);
    end
  end

  // ptr advances when a grant starts, so a stop mid-grant resumes after that channel.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SEEK;
            busy_d  = 1'b1;
          end
        end
        SEEK: begin
          busy_d = 1'b1;
          if (found) begin
            state_d = GRANT;
            sel_d   = hit;
            ptr_d   = hit + 2'd1;
            cnt_d   = LOAD;
            en_d    = 1'b1;
            done_d  = (LOAD == '0) && (hit == top_bit);
          end
        end
        GRANT: begin
          busy_d = 1'b1;
          if (!bus.req[sel_q] || (cnt_q == '0)) begin
            state_d = SEEK;
            ptr_d   = sel_q + 2'd1;
          end else begin
            cnt_d  = cnt_q - CW'(1);
            en_d   = 1'b1;
            done_d = (cnt_q == CW'(1)) && (sel_q == top_bit);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a          = sel_q[1];
  assign bus.b          = sel_q[0];
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

endmodule

// File: doc/dec_scan_sequencer.md
Name: dec_scan_sequencer

Overview:
- Round-robin channel scan controller that drives the select/enable inputs of the 2-to-4 enable decoder.
- Walks the four channels and skips any channel whose request bit is low.
- Holds each granted channel for a programmable dwell time and inserts one idle gap cycle between grants.
- All outputs are registered and wire directly to the decoder inputs a, b, en.

Parameters:
DWELL, 4, cycles en stays high per grant (legal range 1..255)
CW, 8, width of the dwell counter (must hold DWELL-1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; begins scanning from IDLE
stop  input  1  forces return to IDLE; has priority over start
req  input  4  per-channel request, bit k = channel k
a  output  1  channel select MSB (decoder a)
b  output  1  channel select LSB (decoder b)
en  output  1  decoder enable; high only during GRANT
busy  output  1  high in SEEK or GRANT
sweep_done  output  1  one-cycle pulse, see below

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, a=0, b=0, en=0, busy=0, sweep_done=0, ptr=0, cnt=0.
- One clock, clk. Reset is asynchronous and active-low (rst_n). Deassertion of rst_n is synchronous to clk upstream.
- {a,b} is the channel index: a is MSB, so channel 2 = a=1, b=0.
- State machine: IDLE, SEEK, GRANT. All outputs are registered from next-state logic.
- IDLE:
  - en=0, busy=0, {a,b} holds its last value.
  - start=1 and stop=0 -> SEEK.
- SEEK:
  - busy=1, en=0.
  - Search req round-robin starting at ptr: ptr, ptr+1, ... mod 4.
  - First set bit k found -> GRANT next cycle with {a,b}=k and cnt=DWELL-1.
  - req==0 -> remain in SEEK indefinitely.
- GRANT:
  - en=1, busy=1, {a,b} stable.
  - cnt decrements by 1 each cycle.
  - cnt==0 -> normal completion: SEEK next cycle, ptr=(k+1) mod 4.
  - en is therefore high for exactly DWELL consecutive cycles.
- Abort: req[k] low while in GRANT -> SEEK next cycle (en=0), ptr=(k+1) mod 4. No sweep_done on an abort.
- stop=1 in any state -> IDLE next cycle: en=0, busy=0. ptr is retained, so a restart resumes round-robin. stop and start asserted together -> IDLE.
- sweep_done:
  - Asserted for exactly one cycle, coincident with the last GRANT cycle of a normal completion.
  - Condition: k is the highest set bit of req sampled in that cycle.
- Latency: start sampled at edge N -> SEEK in cycle N+1 -> en=1 from cycle N+2.
- Gap: at least one cycle with en=0 between any two grants, including when the same channel is regranted (req=0001).
- Wrap-around: ptr increments modulo 4 (3 -> 0). The search covers all four bits in one cycle, as combinational priority from ptr.
- DWELL=1: GRANT lasts one cycle; cnt is loaded with 0.
- Reset asserted mid-GRANT: en drops immediately (asynchronously), with no glitch to another channel index.

Test Plan:
1. DWELL=4, req=1111, start pulse at cycle 0 -> en=1 with sel 0 in cycles 2-5, gap at 6, sel 1 in 7-10, sel 2 in 12-15, sel 3 in 17-20; sweep_done=1 only in cycle 20; sel 0 again from cycle 22.
2. req=1010, start -> grants alternate ch1, ch3, ch1; sweep_done on the last cycle of each ch3 grant; channels 0 and 2 are never selected.
3. start with req=0000 -> busy=1, en=0 held for 10 cycles; set req=0100 -> en=1 with a=1, b=0 exactly 1 cycle later, for DWELL cycles.
4. req=1111, drop req[1] in the 2nd cycle of the ch1 grant -> en=0 next cycle, one SEEK cycle, then ch2 granted; no sweep_done.
5. stop in the 3rd GRANT cycle of ch2 -> en=0 and busy=0 next cycle. Restart -> ch3 is granted first (ptr kept). start and stop asserted together in IDLE -> stays in IDLE.
6. rst_n low mid-grant of ch3 -> en, a, b, busy go to 0 without a clock edge. After release with start -> ch0 granted first.
